// File: rtl/matrix_loader.sv
// Streams matrix A (MxK) then B (KxN), row-major, into operand banks and pulses start when complete.
// Optional in_last framing check enabled by defining MATRIX_LOADER_LAST_CHECK_EN.
module matrix_loader #(
    parameter int unsigned K          = 3,
    parameter int unsigned N          = 3,
    parameter int unsigned M          = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    input  logic                         reload,
    output logic [M*K*DATA_WIDTH-1:0]    a_flat,
    output logic [K*N*DATA_WIDTH-1:0]    b_flat,
    output logic                         start,
    output logic                         loaded,
    output logic                         frame_err
);

    localparam int unsigned A_N     = M * K;
    localparam int unsigned B_N     = K * N;
    localparam int unsigned MAX_MK  = (M > K) ? M : K;
    localparam int unsigned MAX_D   = (MAX_MK > N) ? MAX_MK : N;
    localparam int unsigned CNT_W   = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam int unsigned A_IDX_W = (A_N > 1) ? $clog2(A_N) : 1;
    localparam int unsigned B_IDX_W = (B_N > 1) ? $clog2(B_N) : 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_row;
    logic [CNT_W-1:0]      r_col;
    logic [DATA_WIDTH-1:0] r_a [A_N];
    logic [DATA_WIDTH-1:0] r_b [B_N];
    logic                  r_start;
    logic                  r_loaded;

    logic                  w_xfer;
    logic                  w_a_col_end;
    logic                  w_a_row_end;
    logic                  w_b_col_end;
    logic                  w_b_row_end;
    logic                  w_last_b;
    logic                  w_frame_bad;
    logic [A_IDX_W-1:0]    w_a_idx;
    logic [B_IDX_W-1:0]    w_b_idx;

    assign in_ready    = (r_state != DONE);
    assign w_xfer      = in_valid && in_ready;
    assign w_a_col_end = (r_col == CNT_W'(K - 1));
    assign w_a_row_end = (r_row == CNT_W'(M - 1));
    assign w_b_col_end = (r_col == CNT_W'(N - 1));
    assign w_b_row_end = (r_row == CNT_W'(K - 1));
    assign w_last_b    = w_b_col_end && w_b_row_end;

    // Multiplies by constant row strides only; no dividers on the address path.
    assign w_a_idx = A_IDX_W'(r_row) * A_IDX_W'(K) + A_IDX_W'(r_col);
    assign w_b_idx = B_IDX_W'(r_row) * B_IDX_W'(N) + B_IDX_W'(r_col);

`ifdef MATRIX_LOADER_LAST_CHECK_EN
    logic r_frame_err;

    // in_last must be set exactly on the final B element.
    assign w_frame_bad = (r_state == LOAD_A) ? in_last : (in_last ^ w_last_b);
    assign frame_err   = r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else if (reload) begin
            r_frame_err <= 1'b0;
        end else if (w_xfer && w_frame_bad) begin
            r_frame_err <= 1'b1;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = in_last;
    assign w_frame_bad   = 1'b0;
    assign frame_err     = 1'b0;
`endif

    // Loader FSM, counters and operand banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= LOAD_A;
            r_row    <= '0;
            r_col    <= '0;
            r_start  <= 1'b0;
            r_loaded <= 1'b0;
            for (int i = 0; i < int'(A_N); i++) r_a[i] <= '0;
            for (int i = 0; i < int'(B_N); i++) r_b[i] <= '0;
        end else begin
            r_start <= 1'b0;
            if (reload) begin
                r_state  <= LOAD_A;
                r_row    <= '0;
                r_col    <= '0;
                r_loaded <= 1'b0;
            end else if (w_xfer && w_frame_bad) begin
                r_state <= LOAD_A;
                r_row   <= '0;
                r_col   <= '0;
            end else if (w_xfer) begin
                case (r_state)
                    LOAD_A: begin
                        r_a[w_a_idx] <= in_data;
                        if (w_a_col_end) begin
                            r_col <= '0;
                            if (w_a_row_end) begin
                                r_row   <= '0;
                                r_state <= LOAD_B;
                            end else begin
                                r_row <= r_row + CNT_W'(1);
                            end
                        end else begin
                            r_col <= r_col + CNT_W'(1);
                        end
                    end
                    LOAD_B: begin
                        r_b[w_b_idx] <= in_data;
                        if (w_b_col_end) begin
                            r_col <= '0;
                            if (w_b_row_end) begin
                                r_row    <= '0;
                                r_state  <= DONE;
                                r_start  <= 1'b1;
                                r_loaded <= 1'b1;
                            end else begin
                                r_row <= r_row + CNT_W'(1);
                            end
                        end else begin
                            r_col <= r_col + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign start  = r_start;
    assign loaded = r_loaded;

    genvar gi;
    generate
        for (gi = 0; gi < int'(A_N); gi++) begin : g_a_flat
            assign a_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_a[gi];
        end
        for (gi = 0; gi < int'(B_N); gi++) begin : g_b_flat
            assign b_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_b[gi];
        end
    endgenerate

endmodule

// File: tb/tb_matrix_loader.sv
// Directed, table-driven bench for matrix_loader (3x3 defaults).
module tb_matrix_loader;

    localparam int unsigned K   = 3;
    localparam int unsigned N   = 3;
    localparam int unsigned M   = 3;
    localparam int unsigned DW  = 8;
    localparam int          NA  = 9;
    localparam int          NEL = 18;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic                  in_last;
    logic                  reload;
    logic [M*K*DW-1:0]     a_flat;
    logic [K*N*DW-1:0]     b_flat;
    logic                  start;
    logic                  loaded;
    logic                  frame_err;

    matrix_loader #(.K(K), .N(N), .M(M), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .reload    (reload),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .start     (start),
        .loaded    (loaded),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       rld;
        logic       exp_ready;
        logic       exp_start;
        logic       exp_loaded;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    function automatic logic [7:0] a_el(input int i);
        return a_flat[i*DW +: DW];
    endfunction

    function automatic logic [7:0] b_el(input int i);
        return b_flat[i*DW +: DW];
    endfunction

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic r,
                       input logic er, input logic es, input logic el, input logic ee);
        vec_t t;
        t.valid = v; t.data = d; t.last = l; t.rld = r;
        t.exp_ready = er; t.exp_start = es; t.exp_loaded = el; t.exp_err = ee;
        vecs.push_back(t);
    endtask

    // One full frame of values base..base+17; optional idle cycles between elements.
    task automatic gen_frame(input int base, input bit toggle, input int extra_last);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        while (n < NEL) begin
            if (toggle && (cyc % 2 == 1)) begin
                add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                n++;
                add(1'b1, 8'(base + n - 1), (n == NEL) || (n == extra_last), 1'b0,
                    n != NEL, n == NEL, n == NEL, 1'b0);
            end
            cyc++;
        end
    endtask

    // Drive on the falling edge, check just after the following rising edge.
    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            in_last  = vecs[i].last;
            reload   = vecs[i].rld;
            @(posedge clk);
            #1;
            check("in_ready",  vec_no, 32'(in_ready),  32'(vecs[i].exp_ready));
            check("start",     vec_no, 32'(start),     32'(vecs[i].exp_start));
            check("loaded",    vec_no, 32'(loaded),    32'(vecs[i].exp_loaded));
            check("frame_err", vec_no, 32'(frame_err), 32'(vecs[i].exp_err));
            vec_no++;
        end
        vecs.delete();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reload   = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_banks(input string name, input int base);
        for (int i = 0; i < NA; i++) begin
            check({name, "_a"}, i, 32'(a_el(i)), 32'(8'(base + i)));
            check({name, "_b"}, i, 32'(b_el(i)), 32'(8'(base + NA + i)));
        end
    endtask

    task automatic check_zero(input string name);
        for (int i = 0; i < NA; i++) begin
            check({name, "_a"}, i, 32'(a_el(i)), 32'h0);
            check({name, "_b"}, i, 32'(b_el(i)), 32'h0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        reload   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready",  0, 32'(in_ready),  32'h1);
        check("rst_start",  0, 32'(start),     32'h0);
        check("rst_loaded", 0, 32'(loaded),    32'h0);
        check("rst_err",    0, 32'(frame_err), 32'h0);
        check_zero("rst_bank");

        // Back-to-back frame, then DONE must ignore valid data.
        gen_frame(1, 1'b0, 0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_table();
        check_banks("seq", 1);

        // Reload from DONE, frame with in_valid toggling.
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        gen_frame(51, 1'b1, 0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_table();
        check_banks("gap", 51);

        // Abort after 7 A elements; the transfer coinciding with reload is dropped.
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b1, 8'(100 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        gen_frame(21, 1'b0, 0);
        run_table();
        check_banks("abort", 21);

        // Reset in the middle of LOAD_B.
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) add(1'b1, 8'(60 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_table();
        check("pre_rst_a0", 0, 32'(a_el(0)), 32'd60);
        check("pre_rst_b2", 0, 32'(b_el(2)), 32'd71);
        rst = 1'b1;
        #1;
        check("mid_rst_ready",  0, 32'(in_ready), 32'h1);
        check("mid_rst_loaded", 0, 32'(loaded),   32'h0);
        check_zero("mid_rst_bank");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 0, 32'(in_ready), 32'h1);
        gen_frame(70, 1'b0, 0);
        run_table();
        check_banks("post_rst", 70);

`ifdef MATRIX_LOADER_LAST_CHECK_EN
        // Early in_last on element 10 aborts the frame and latches frame_err.
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) add(1'b1, 8'(90 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'd99, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_table();
        check("err_restart_a0", 0, 32'(a_el(0)), 32'hAA);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        gen_frame(110, 1'b0, 0);
        run_table();
        check_banks("last_ok", 110);
`else
        // in_last is ignored: a stray in_last on element 10 does not disturb the frame.
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        gen_frame(110, 1'b0, 10);
        run_table();
        check_banks("last_ign", 110);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
